// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe -- pipelined WIDTH-bit barrel shifter with valid/ready flow.
//
// Shifts data_operandA by ctrl_shiftamt (0..WIDTH-1). Shift level k moves the
// word by 2^k when ctrl_shiftamt[k] is set; levels run in ascending k and are
// grouped REG_EVERY per pipeline stage, giving L = ceil(log2(WIDTH)/REG_EVERY)
// stages. Each stage register holds the partial data, the shift amount, the
// mode, the original operand MSB (SRA fill) and a valid bit.
//
// Modes (ctrl_mode): 00 SLL, 01 SRL, 10 SRA, 11 ROR.
// Build option: define SHIFT_ROTATE_EN to enable rotate-right for mode 11;
// without it mode 11 behaves as SRL and the wrap-around muxing is not built.
//
// Ports:
//   clock, reset              clock; synchronous active-high reset
//   in_valid / in_ready       operation handshake (in_ready is combinational
//                             from out_ready and the stage valid bits only)
//   data_operandA             operand
//   ctrl_shiftamt             shift amount, log2(WIDTH) bits
//   ctrl_mode                 shift mode
//   out_valid / out_ready     result handshake
//   out_data, out_zero        result and result==0, straight from the last
//                             stage register

// Combinational shift levels [LO, HI) of one pipeline stage.
module barrel_shift_stage #(
  parameter int WIDTH = 32,
  parameter int N     = 5,
  parameter int LO    = 0,
  parameter int HI    = 2
) (
  input  logic [WIDTH-1:0] din,
  input  logic [N-1:0]     amt,
  input  logic [1:0]       mode,
  input  logic             msb,
  output logic [WIDTH-1:0] dout
);
  always_comb begin
    dout = din;
    for (int k = 0; k < N; k++) begin
      if (k >= LO && k < HI && amt[k]) begin
        case (mode)
          2'b00: dout = dout << (2**k);
          // Fill with the original operand MSB, carried alongside the data,
          // so partial results never need to be re-inspected for sign.
          2'b10: dout = (dout >> (2**k)) | ({WIDTH{msb}} << (WIDTH - 2**k));
`ifdef SHIFT_ROTATE_EN
          2'b11: dout = (dout >> (2**k)) | (dout << (WIDTH - 2**k));
`endif
          default: dout = dout >> (2**k);
        endcase
      end
    end
  end
endmodule

module barrel_shift_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2,
  localparam int N        = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [N-1:0]     ctrl_shiftamt,
  input  logic [1:0]       ctrl_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);
  localparam int L  = (N + REG_EVERY - 1) / REG_EVERY;
  // Side-band registers only exist between stages; the last stage needs data only.
  localparam int ML = (L > 1) ? L - 1 : 1;

  logic [L-1:0][WIDTH-1:0] data_q, st_din, st_dout;
  logic [L-1:0]            vld_pipe, adv, st_vin, st_msb;
  logic [L-1:0][N-1:0]     st_amt;
  logic [L-1:0][1:0]       st_mode;
  logic [ML-1:0][N-1:0]    amt_q;
  logic [ML-1:0][1:0]      mode_q;
  logic [ML-1:0]           msb_q;
  logic                    zero_q;

  // A stage may load when it is empty or everything after it can move.
  // Walking from the output back lets any bubble absorb upstream data.
  always_comb begin
    logic run;
    adv = '0;
    run = out_ready;
    for (int s = L - 1; s >= 0; s--) begin
      run    = run || !vld_pipe[s];
      adv[s] = run;
    end
  end

  assign in_ready = adv[0];

  // Stage inputs: ports for stage 0, previous stage register otherwise.
  always_comb begin
    st_din  = '0;
    st_amt  = '0;
    st_mode = '0;
    st_msb  = '0;
    st_vin  = '0;
    st_din[0]  = data_operandA;
    st_amt[0]  = ctrl_shiftamt;
    st_mode[0] = ctrl_mode;
    st_msb[0]  = data_operandA[WIDTH-1];
    st_vin[0]  = in_valid;
    for (int s = 1; s < L; s++) begin
      st_din[s]  = data_q[s-1];
      st_amt[s]  = amt_q[s-1];
      st_mode[s] = mode_q[s-1];
      st_msb[s]  = msb_q[s-1];
      st_vin[s]  = vld_pipe[s-1];
    end
  end

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int LO = s * REG_EVERY;
    localparam int HI = ((s + 1) * REG_EVERY > N) ? N : (s + 1) * REG_EVERY;
    barrel_shift_stage #(.WIDTH(WIDTH), .N(N), .LO(LO), .HI(HI)) u_stage (
      .din (st_din[s]),
      .amt (st_amt[s]),
      .mode(st_mode[s]),
      .msb (st_msb[s]),
      .dout(st_dout[s])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      data_q   <= '0;
      amt_q    <= '0;
      mode_q   <= '0;
      msb_q    <= '0;
      zero_q   <= 1'b1;
    end else begin
      for (int s = 0; s < L; s++) begin
        if (adv[s]) begin
          vld_pipe[s] <= st_vin[s];
          // Payload only moves with a valid op; bubbles leave it untouched.
          if (st_vin[s]) data_q[s] <= st_dout[s];
        end
      end
      for (int s = 0; s < L - 1; s++) begin
        if (adv[s] && st_vin[s]) begin
          amt_q[s]  <= st_amt[s];
          mode_q[s] <= st_mode[s];
          msb_q[s]  <= st_msb[s];
        end
      end
      // Registered zero flag keeps out_zero free of combinational logic.
      if (adv[L-1] && st_vin[L-1]) zero_q <= (st_dout[L-1] == '0);
    end
  end

  assign out_valid = vld_pipe[L-1];
  assign out_data  = data_q[L-1];
  assign out_zero  = zero_q;
endmodule

// File: tb/tb_barrel_shift_pipe.sv
module tb_barrel_shift_pipe;
  localparam int L = 3;
  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROR = 2'b11;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [31:0] data_operandA, out_data;
  logic [4:0]  ctrl_shiftamt;
  logic [1:0]  ctrl_mode;
  int          n_chk = 0, n_bad = 0;

  always #5 clock = ~clock;

  barrel_shift_pipe #(.WIDTH(32), .REG_EVERY(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_operandA(data_operandA),
    .ctrl_shiftamt(ctrl_shiftamt),
    .ctrl_mode    (ctrl_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_zero     (out_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model for the random sweep, written as whole-word shifts.
  function automatic logic [31:0] ref_shift(logic [31:0] a, logic [4:0] sh, logic [1:0] m);
    case (m)
      SLL: return a << sh;
      SRA: return 32'($signed(a) >>> sh);
`ifdef SHIFT_ROTATE_EN
      ROR: return (a >> sh) | (a << (6'd32 - {1'b0, sh}));
`endif
      default: return a >> sh;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single op through an idle pipe: latency, data, zero flag, drain.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] sh,
                        input logic [1:0] m, input logic [31:0] exp);
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1; data_operandA = a; ctrl_shiftamt = sh; ctrl_mode = m;
    #1;
    chk({tag, "_rdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, L);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_zero"}, out_zero, (exp == 32'd0));
    tick();
    chk({tag, "_drain"}, out_valid, 0);
  endtask

  task automatic bp_test();
    int issued = 0, popped = 0, inflight;
    logic stall_prev = 1'b0, seen_full = 1'b0;
    logic [31:0] data_prev = '0;
    for (int cyc = 0; cyc < 60 && popped < 8; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 9);
      in_valid = (issued < 8);
      data_operandA = 32'd1; ctrl_shiftamt = 5'(issued); ctrl_mode = SLL;
      #1;
      inflight = issued - popped;
      chk("bp_in_ready", in_ready, (inflight < L) || out_ready);
      if (inflight == L && !in_ready) seen_full = 1'b1;
      if (stall_prev) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data", out_data, data_prev);
      end
      stall_prev = out_valid && !out_ready;
      data_prev = out_data;
      if (out_valid && out_ready) begin
        chk("bp_order", out_data, 32'd1 << popped);
        popped++;
      end
      if (in_valid && in_ready) issued++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_count", popped, 8);
    chk("bp_full_seen", seen_full, 1);
  endtask

  task automatic reset_midflight();
    int seen = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; data_operandA = 32'hA5A5_0000 + i; ctrl_shiftamt = 5'd1; ctrl_mode = SLL;
      tick();
    end
    reset = 1'b1;
    data_operandA = 32'h0000_00F0;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_zero", out_zero, 1);
    chk("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("rst_no_stale", seen, 0);
  endtask

  task automatic random_sweep();
    logic [31:0] q[$];
    logic [31:0] exp;
    int issued = 0, popped = 0, inflight;
    for (int cyc = 0; cyc < 60000 && popped < 10000; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = (issued < 10000) && ($urandom_range(0, 3) != 0);
      data_operandA = $urandom;
      ctrl_shiftamt = 5'($urandom_range(0, 31));
      ctrl_mode = 2'($urandom_range(0, 3));
      #1;
      inflight = issued - popped;
      chk("rnd_in_ready", in_ready, (inflight < L) || out_ready);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_extra", out_valid, 0);
        end else begin
          exp = q.pop_front();
          chk("rnd_data", out_data, exp);
          chk("rnd_zero", out_zero, (exp == 32'd0));
        end
        popped++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_shift(data_operandA, ctrl_shiftamt, ctrl_mode));
        issued++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("rnd_count", popped, 10000);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    data_operandA = '0; ctrl_shiftamt = '0; ctrl_mode = SLL;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 32'd0);
    chk("reset_zero", out_zero, 1);
    chk("reset_in_ready", in_ready, 1);

    run_op("sll8",    32'h0000_00FF, 5'd8,  SLL, 32'h0000_FF00);
    run_op("sra31",   32'h8000_0000, 5'd31, SRA, 32'hFFFF_FFFF);
    run_op("srl31",   32'h8000_0000, 5'd31, SRL, 32'h0000_0001);
    run_op("sll0",    32'h1234_5678, 5'd0,  SLL, 32'h1234_5678);
    run_op("sra_pos", 32'h7FFF_FFF0, 5'd4,  SRA, 32'h07FF_FFFF);
    run_op("sra0",    32'hF000_0000, 5'd0,  SRA, 32'hF000_0000);
    run_op("sll_msb", 32'h8000_0001, 5'd1,  SLL, 32'h0000_0002);
    run_op("ror0",    32'hDEAD_BEEF, 5'd0,  ROR, 32'hDEAD_BEEF);
`ifdef SHIFT_ROTATE_EN
    run_op("ror1",    32'h0000_0001, 5'd1,  ROR, 32'h8000_0000);
    run_op("ror4",    32'h1234_5678, 5'd4,  ROR, 32'h8123_4567);
`else
    run_op("ror1",    32'h0000_0001, 5'd1,  ROR, 32'h0000_0000);
    run_op("ror4",    32'h1234_5678, 5'd4,  ROR, 32'h0123_4567);
`endif

    bp_test();
    reset_midflight();
    random_sweep();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
